// File: rtl/reg_file_bist_ctrl.sv
// Built-in self test for the 32x32 register file: writes a pattern, reads it back
// on both read ports and counts mismatches, first with the true pattern, then inverted.
module reg_file_bist_ctrl #(
    parameter logic [31:0] SEED    = 32'h00414020,
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [7:0]  ERR_COUNT,
    output logic [4:0]  FAIL_ADDR,
    output logic [4:0]  ADDR_W,
    output logic [31:0] DATA_W,
    output logic [4:0]  ADDR_R1,
    output logic [4:0]  ADDR_R2,
    output logic        READ,
    output logic        WRITE,
    input  logic [31:0] DATA_R1,
    input  logic [31:0] DATA_R2
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CHK, S_FIN} state_e;

    state_e      state_q;
    logic        pass_q;
    logic [4:0]  idx_q;
    logic [4:0]  idx_inc;
    logic        busy_q, done_q, ok_q;
    logic [7:0]  err_q, err_d;
    logic [4:0]  fail_addr_q, fail_addr_d;
    logic        seen_q, seen_d;
    logic [4:0]  addr_w_q, addr_r1_q, addr_r2_q;
    logic [31:0] data_w_q;
    logic        read_q, write_q;
    logic [31:0] exp1_q, exp2_q;
    logic        cmp_v_q;
    logic [31:0] cexp1_q, cexp2_q;
    logic [4:0]  caddr1_q, caddr2_q;
    logic        mis1, mis2;
    logic [8:0]  err_sum;

    function automatic logic [31:0] pattern(input logic [4:0] a, input logic inv);
        logic [31:0] p;
        p = SEED + {27'd0, a};
        return inv ? ~p : p;
    endfunction

    function automatic logic [31:0] expected(input logic [4:0] a, input logic inv);
        if (R0_ZERO && (a == 5'd0))
            return '0;
        return pattern(a, inv);
    endfunction

    // Read data appears one edge after the strobe; expectations are carried one
    // extra stage so the compare lands on the edge after that.
    always_comb begin
        idx_inc     = idx_q + 5'd1;
        mis1        = cmp_v_q && (DATA_R1 !== cexp1_q);
        mis2        = cmp_v_q && (DATA_R2 !== cexp2_q);
        err_sum     = {1'b0, err_q} + {8'd0, mis1} + {8'd0, mis2};
        err_d       = err_sum[8] ? 8'hFF : err_sum[7:0];
        fail_addr_d = fail_addr_q;
        if (!seen_q && mis1)
            fail_addr_d = caddr1_q;
        else if (!seen_q && mis2)
            fail_addr_d = caddr2_q;
        seen_d      = seen_q | mis1 | mis2;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            pass_q      <= 1'b0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            seen_q      <= 1'b0;
            addr_w_q    <= '0;
            data_w_q    <= '0;
            addr_r1_q   <= '0;
            addr_r2_q   <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            exp1_q      <= '0;
            exp2_q      <= '0;
            cmp_v_q     <= 1'b0;
            cexp1_q     <= '0;
            cexp2_q     <= '0;
            caddr1_q    <= '0;
            caddr2_q    <= '0;
        end else begin
            cmp_v_q     <= read_q;
            cexp1_q     <= exp1_q;
            cexp2_q     <= exp2_q;
            caddr1_q    <= addr_r1_q;
            caddr2_q    <= addr_r2_q;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            seen_q      <= seen_d;
            case (state_q)
                S_IDLE, S_FIN: begin
                    if (START) begin
                        state_q     <= S_WR;
                        pass_q      <= 1'b0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        ok_q        <= 1'b0;
                        err_q       <= '0;
                        fail_addr_q <= '0;
                        seen_q      <= 1'b0;
                        write_q     <= 1'b1;
                        addr_w_q    <= '0;
                        data_w_q    <= pattern(5'd0, 1'b0);
                    end
                end
                S_WR: begin
                    if (idx_q == 5'd31) begin
                        state_q   <= S_RD;
                        idx_q     <= '0;
                        write_q   <= 1'b0;
                        addr_w_q  <= '0;
                        data_w_q  <= '0;
                        read_q    <= 1'b1;
                        addr_r1_q <= 5'd0;
                        addr_r2_q <= 5'd31;
                        exp1_q    <= expected(5'd0, pass_q);
                        exp2_q    <= expected(5'd31, pass_q);
                    end else begin
                        idx_q    <= idx_inc;
                        addr_w_q <= idx_inc;
                        data_w_q <= pattern(idx_inc, pass_q);
                    end
                end
                S_RD: begin
                    if (idx_q == 5'd31) begin
                        state_q   <= S_CHK;
                        idx_q     <= '0;
                        read_q    <= 1'b0;
                        addr_r1_q <= '0;
                        addr_r2_q <= '0;
                    end else begin
                        idx_q     <= idx_inc;
                        addr_r1_q <= idx_inc;
                        addr_r2_q <= 5'd31 - idx_inc;
                        exp1_q    <= expected(idx_inc, pass_q);
                        exp2_q    <= expected(5'd31 - idx_inc, pass_q);
                    end
                end
                S_CHK: begin
                    if (!pass_q) begin
                        state_q  <= S_WR;
                        pass_q   <= 1'b1;
                        idx_q    <= '0;
                        write_q  <= 1'b1;
                        addr_w_q <= '0;
                        data_w_q <= pattern(5'd0, 1'b1);
                    end else begin
                        // err_d includes the final read compared on this edge
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ok_q    <= (err_d == 8'd0);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = ok_q;
    assign ERR_COUNT = err_q;
    assign FAIL_ADDR = fail_addr_q;
    assign ADDR_W    = addr_w_q;
    assign DATA_W    = data_w_q;
    assign ADDR_R1   = addr_r1_q;
    assign ADDR_R2   = addr_r2_q;
    assign READ      = read_q;
    assign WRITE     = write_q;

endmodule
